// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Entry layout and error-bit positions used by the RX FIFO.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  typedef logic [2:0] rx_err_t;

  typedef struct packed {
    logic [DATA_BITS_DEF-1:0] data;
    rx_err_t                  err;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array.
// One synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the host read port.
// First-word-fall-through queue of {data, err} with flow control.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_BITS     = DATA_BITS_DEF,
  parameter  int FIFO_DEPTH    = 8,
  parameter  int RTS_THRESHOLD = 6,
  localparam int PW            = $clog2(FIFO_DEPTH),
  localparam int CW            = PW + 1
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Wr_Data,
  input  logic [2:0]           Wr_Err,
  input  logic                 Data_Rdy,
  input  logic                 Read_Done,
  input  logic                 Ovf_Clr,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Err_Out,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS,
  output logic [CW-1:0]        Count
);

  localparam int EW = DATA_BITS + 3;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;
  logic [EW-1:0] head;
  rx_err_t       head_err;

  assign FIFO_Empty = (count_q == '0);
  assign FIFO_Full  = (count_q == CW'(FIFO_DEPTH));
  assign RTS        = (count_q < CW'(RTS_THRESHOLD));
  assign Count      = count_q;

  // A full FIFO still accepts a write when the host pops in the same cycle.
  assign push = Data_Rdy && (!FIFO_Full || Read_Done);
  assign pop  = Read_Done && !FIFO_Empty;
  assign drop = Data_Rdy && FIFO_Full && !Read_Done;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (Ovf_Clr) ovf_d = 1'b0;
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign FIFO_Overflow = ovf_q;

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk_i   (SysClk),
    .we_i    (push && !Rst),
    .waddr_i (wr_ptr_q),
    .wdata_i ({Wr_Data, Wr_Err}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign head_err = FIFO_Empty ? rx_err_t'(0) : head[2:0];
  assign Err_Out  = head_err;
  assign Data_Out = FIFO_Empty ? '0 : head[EW-1:3];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Linear stimulus with hand-computed expectations.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       SysClk;
  logic       Rst;
  logic [7:0] Wr_Data;
  logic [2:0] Wr_Err;
  logic       Data_Rdy;
  logic       Read_Done;
  logic       Ovf_Clr;
  logic [7:0] Data_Out;
  logic [2:0] Err_Out;
  logic       FIFO_Empty;
  logic       FIFO_Full;
  logic       FIFO_Overflow;
  logic       RTS;
  logic [3:0] Count;

  int checks;
  int failures;

  uart_rx_fifo dut (
    .SysClk        (SysClk),
    .Rst           (Rst),
    .Wr_Data       (Wr_Data),
    .Wr_Err        (Wr_Err),
    .Data_Rdy      (Data_Rdy),
    .Read_Done     (Read_Done),
    .Ovf_Clr       (Ovf_Clr),
    .Data_Out      (Data_Out),
    .Err_Out       (Err_Out),
    .FIFO_Empty    (FIFO_Empty),
    .FIFO_Full     (FIFO_Full),
    .FIFO_Overflow (FIFO_Overflow),
    .RTS           (RTS),
    .Count         (Count)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cyc(input logic dr, input logic [7:0] d,
                     input logic [2:0] e, input logic rd,
                     input logic clr, input logic rst);
    Data_Rdy  = dr;
    Wr_Data   = d;
    Wr_Err    = e;
    Read_Done = rd;
    Ovf_Clr   = clr;
    Rst       = rst;
    @(posedge SysClk);
    #1;
    Data_Rdy  = 1'b0;
    Read_Done = 1'b0;
    Ovf_Clr   = 1'b0;
    Rst       = 1'b0;
    Wr_Data   = '0;
    Wr_Err    = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(FIFO_Empty), 32'd1);
    chk({tag, "_full"}, 32'(FIFO_Full), 32'd0);
    chk({tag, "_ovf"}, 32'(FIFO_Overflow), 32'd0);
    chk({tag, "_rts"}, 32'(RTS), 32'd1);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_dout"}, 32'(Data_Out), 32'd0);
    chk({tag, "_eout"}, 32'(Err_Out), 32'd0);
  endtask

  initial begin
    logic [2:0] perr;
    logic [2:0] mix;
    checks    = 0;
    failures  = 0;
    Data_Rdy  = 1'b0;
    Read_Done = 1'b0;
    Ovf_Clr   = 1'b0;
    Wr_Data   = '0;
    Wr_Err    = '0;
    Rst       = 1'b1;
    perr      = '0;
    perr[ERR_PARITY] = 1'b1;
    mix       = '0;
    mix[ERR_BREAK] = 1'b1;
    mix[ERR_FRAME] = 1'b1;

    cyc(0, 8'h00, 3'd0, 0, 0, 1);
    cyc(0, 8'h00, 3'd0, 0, 0, 1);
    chk_reset("rst");

    cyc(1, 8'h41, 3'd0, 0, 0, 0);
    chk("p41_dout", 32'(Data_Out), 32'h41);
    chk("p41_empty", 32'(FIFO_Empty), 32'd0);
    chk("p41_count", 32'(Count), 32'd1);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    chk("pop41_empty", 32'(FIFO_Empty), 32'd1);
    chk("pop41_dout", 32'(Data_Out), 32'd0);

    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    chk("underflow_count", 32'(Count), 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i), 3'd0, 0, 0, 0);
      chk("fill_count", 32'(Count), 32'(i + 1));
      chk("fill_rts", 32'(RTS), 32'((i + 1) < 6));
    end
    chk("fill_full", 32'(FIFO_Full), 32'd1);
    chk("fill_head", 32'(Data_Out), 32'h00);

    cyc(1, 8'hAA, 3'd0, 0, 0, 0);
    chk("ovf_set", 32'(FIFO_Overflow), 32'd1);
    chk("ovf_count", 32'(Count), 32'd8);
    chk("ovf_head", 32'(Data_Out), 32'h00);
    cyc(0, 8'h00, 3'd0, 0, 1, 0);
    chk("ovf_clr", 32'(FIFO_Overflow), 32'd0);
    cyc(1, 8'hAA, 3'd0, 0, 1, 0);
    chk("ovf_setwins", 32'(FIFO_Overflow), 32'd1);
    cyc(0, 8'h00, 3'd0, 0, 1, 0);
    chk("ovf_clr2", 32'(FIFO_Overflow), 32'd0);

    cyc(1, 8'h55, 3'd0, 1, 0, 0);
    chk("fullrw_count", 32'(Count), 32'd8);
    chk("fullrw_ovf", 32'(FIFO_Overflow), 32'd0);
    chk("fullrw_head", 32'(Data_Out), 32'h01);

    for (int i = 1; i < 8; i++) begin
      chk("drain_data", 32'(Data_Out), 32'(i));
      cyc(0, 8'h00, 3'd0, 1, 0, 0);
    end
    chk("drain_last", 32'(Data_Out), 32'h55);
    chk("drain_cnt1", 32'(Count), 32'd1);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    chk("drain_empty", 32'(FIFO_Empty), 32'd1);

    cyc(1, 8'h3C, perr, 0, 0, 0);
    chk("err_eout", 32'(Err_Out), 32'h2);
    chk("err_dout", 32'(Data_Out), 32'h3C);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    chk("err_pop", 32'(Err_Out), 32'h0);

    cyc(1, 8'h77, mix, 1, 0, 0);
    chk("emptyrw_count", 32'(Count), 32'd1);
    chk("emptyrw_dout", 32'(Data_Out), 32'h77);
    chk("emptyrw_eout", 32'(Err_Out), 32'h5);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);

    for (int i = 0; i < 5; i++) cyc(1, 8'hC0 + 8'(i), 3'd1, 0, 0, 0);
    chk("pre_rst_count", 32'(Count), 32'd5);
    cyc(0, 8'h00, 3'd0, 0, 0, 1);
    chk_reset("midrst");

    for (int j = 0; j < 3; j++) cyc(1, 8'h10 + 8'(j), 3'd0, 0, 0, 0);
    for (int j = 3; j < 23; j++) begin
      cyc(1, 8'h10 + 8'(j), 3'd0, 1, 0, 0);
      chk("wrap_head", 32'(Data_Out), 32'(8'h10 + 8'(j - 2)));
      chk("wrap_count", 32'(Count), 32'd3);
    end
    for (int j = 20; j < 23; j++) begin
      chk("wrap_drain", 32'(Data_Out), 32'(8'h10 + 8'(j)));
      cyc(0, 8'h00, 3'd0, 1, 0, 0);
    end
    chk("wrap_empty", 32'(FIFO_Empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
